// File: rtl/reg_wb_pkg.sv
// rtl/reg_wb_pkg.sv - shared widths, requester ids and write-port bundle for the writeback arbiter
package reg_wb_pkg;

    localparam int WB_DATA_W = 32;
    localparam int WB_ADDR_W = 4;
    localparam int WB_NREG   = 1 << WB_ADDR_W;

    localparam logic REQ_ALU = 1'b0;
    localparam logic REQ_LD  = 1'b1;

    typedef struct packed {
        logic                 w_en;
        logic [WB_ADDR_W-1:0] addr;
        logic [WB_DATA_W-1:0] data;
    } wb_port_t;

    // Round-robin pick: the load wins a conflict when the ALU was granted last.
    function automatic logic rr_pick_ld(input logic last_grant);
        return (last_grant == REQ_ALU);
    endfunction

endpackage

// File: rtl/wb_scoreboard.sv
// rtl/wb_scoreboard.sv - per-register busy bits: reserved at issue, released when the write lands
module wb_scoreboard
    import reg_wb_pkg::*;
#(
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              set_en_i,
    input  logic [ADDR_W-1:0] set_addr_i,
    output logic              set_ok_o,
    input  logic              clr_en_i,
    input  logic [ADDR_W-1:0] clr_addr_i,
    input  logic [ADDR_W-1:0] rn_i,
    input  logic [ADDR_W-1:0] rm_i,
    output logic              rn_busy_o,
    output logic              rm_busy_o
);

    localparam int NREG = 1 << ADDR_W;

    logic [NREG-1:0] busy_q;
    logic [NREG-1:0] busy_d;
    logic [NREG-1:0] set_vec;
    logic [NREG-1:0] clr_vec;

    assign set_ok_o  = ~busy_q[set_addr_i];
    assign rn_busy_o = busy_q[rn_i];
    assign rm_busy_o = busy_q[rm_i];

    // Set is OR-ed in after the clear so a same-cycle reserve of the written register survives.
    always_comb begin
        set_vec = '0;
        clr_vec = '0;
        if (set_en_i && set_ok_o) begin
            set_vec[set_addr_i] = 1'b1;
        end
        if (clr_en_i) begin
            clr_vec[clr_addr_i] = 1'b1;
        end
        busy_d = (busy_q & ~clr_vec) | set_vec;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy_q <= '0;
        end else begin
            busy_q <= busy_d;
        end
    end

endmodule

// File: rtl/reg_wb_arbiter.sv
// rtl/reg_wb_arbiter.sv - ALU/load writeback arbiter with registered RF write port; WB_RR_EN selects round-robin
module reg_wb_arbiter
    import reg_wb_pkg::*;
#(
    parameter int DATA_W = WB_DATA_W,
    parameter int ADDR_W = WB_ADDR_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              alu_valid,
    output logic              alu_ready,
    input  logic [ADDR_W-1:0] alu_rd,
    input  logic [DATA_W-1:0] alu_data,
    input  logic              ld_valid,
    output logic              ld_ready,
    input  logic [ADDR_W-1:0] ld_rd,
    input  logic [DATA_W-1:0] ld_data,
    output logic              rf_w_en,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic [DATA_W-1:0] rf_rd_data,
    input  logic              iss_valid,
    input  logic [ADDR_W-1:0] iss_rd,
    output logic              iss_ok,
    input  logic [ADDR_W-1:0] chk_rn,
    input  logic [ADDR_W-1:0] chk_rm,
    output logic              rn_busy,
    output logic              rm_busy
);

    logic     alu_gnt;
    logic     ld_gnt;
    wb_port_t wport_q;
    wb_port_t wport_d;

`ifdef WB_RR_EN
    logic last_q;
    logic last_d;

    always_comb begin
        alu_gnt = 1'b0;
        ld_gnt  = 1'b0;
        if (alu_valid && ld_valid) begin
            if (rr_pick_ld(last_q)) begin
                ld_gnt = 1'b1;
            end else begin
                alu_gnt = 1'b1;
            end
        end else begin
            alu_gnt = alu_valid;
            ld_gnt  = ld_valid;
        end
        last_d = last_q;
        if (ld_gnt) begin
            last_d = REQ_LD;
        end else if (alu_gnt) begin
            last_d = REQ_ALU;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_q <= REQ_ALU;
        end else begin
            last_q <= last_d;
        end
    end
`else
    assign ld_gnt  = ld_valid;
    assign alu_gnt = alu_valid & ~ld_valid;
`endif

    // Nothing is accepted while reset is held, even with requests pending.
    assign alu_ready = alu_gnt & rst_n;
    assign ld_ready  = ld_gnt & rst_n;

    always_comb begin
        wport_d      = wport_q;
        wport_d.w_en = 1'b0;
        if (ld_gnt) begin
            wport_d.w_en = 1'b1;
            wport_d.addr = ld_rd;
            wport_d.data = ld_data;
        end else if (alu_gnt) begin
            wport_d.w_en = 1'b1;
            wport_d.addr = alu_rd;
            wport_d.data = alu_data;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wport_q <= '0;
        end else begin
            wport_q <= wport_d;
        end
    end

    assign rf_w_en    = wport_q.w_en;
    assign rf_rd_addr = wport_q.addr;
    assign rf_rd_data = wport_q.data;

    wb_scoreboard #(
        .ADDR_W (ADDR_W)
    ) u_scoreboard (
        .clk        (clk),
        .rst_n      (rst_n),
        .set_en_i   (iss_valid),
        .set_addr_i (iss_rd),
        .set_ok_o   (iss_ok),
        .clr_en_i   (wport_q.w_en),
        .clr_addr_i (wport_q.addr),
        .rn_i       (chk_rn),
        .rm_i       (chk_rm),
        .rn_busy_o  (rn_busy),
        .rm_busy_o  (rm_busy)
    );

endmodule

// File: tb/tb_reg_wb_arbiter.sv
// tb/tb_reg_wb_arbiter.sv - table-driven bench with write scoreboard for reg_wb_arbiter
module tb_reg_wb_arbiter;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        alu_valid, alu_ready, ld_valid, ld_ready;
    logic [3:0]  alu_rd, ld_rd;
    logic [31:0] alu_data, ld_data;
    logic        rf_w_en;
    logic [3:0]  rf_rd_addr;
    logic [31:0] rf_rd_data;
    logic        iss_valid, iss_ok, rn_busy, rm_busy;
    logic [3:0]  iss_rd, chk_rn, chk_rm;

    always #5 clk = ~clk;

    reg_wb_arbiter dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .alu_rd     (alu_rd),
        .alu_data   (alu_data),
        .ld_valid   (ld_valid),
        .ld_ready   (ld_ready),
        .ld_rd      (ld_rd),
        .ld_data    (ld_data),
        .rf_w_en    (rf_w_en),
        .rf_rd_addr (rf_rd_addr),
        .rf_rd_data (rf_rd_data),
        .iss_valid  (iss_valid),
        .iss_rd     (iss_rd),
        .iss_ok     (iss_ok),
        .chk_rn     (chk_rn),
        .chk_rm     (chk_rm),
        .rn_busy    (rn_busy),
        .rm_busy    (rm_busy)
    );

    typedef struct {
        logic        av;
        logic [3:0]  ard;
        logic [31:0] adat;
        logic        lv;
        logic [3:0]  lrd;
        logic [31:0] ldat;
        logic        iv;
        logic [3:0]  ird;
        logic [3:0]  rn;
        logic [3:0]  rm;
        logic        e_ar;
        logic        e_lr;
        logic        e_ok;
        logic        e_rnb;
        logic        e_rmb;
    } vec_t;

    typedef struct {
        logic [3:0]  a;
        logic [31:0] d;
    } wr_t;

    vec_t        tbl[$];
    wr_t         exp_q[$];
    logic [3:0]  last_a;
    logic [31:0] last_d;
    int          n_vec = 0;
    int          n_err = 0;

    function automatic vec_t mk(input logic av, input logic [3:0] ard, input logic [31:0] adat,
                                input logic lv, input logic [3:0] lrd, input logic [31:0] ldat,
                                input logic iv, input logic [3:0] ird,
                                input logic [3:0] rn, input logic [3:0] rm,
                                input logic e_ar, input logic e_lr, input logic e_ok,
                                input logic e_rnb, input logic e_rmb);
        vec_t v;
        v.av = av; v.ard = ard; v.adat = adat;
        v.lv = lv; v.lrd = lrd; v.ldat = ldat;
        v.iv = iv; v.ird = ird; v.rn = rn; v.rm = rm;
        v.e_ar = e_ar; v.e_lr = e_lr; v.e_ok = e_ok; v.e_rnb = e_rnb; v.e_rmb = e_rmb;
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic check_wr();
        wr_t w;
        if (exp_q.size() > 0) begin
            w = exp_q.pop_front();
            chk("rf_w_en", {31'b0, rf_w_en}, 32'd1);
            chk("rf_rd_addr", {28'b0, rf_rd_addr}, {28'b0, w.a});
            chk("rf_rd_data", rf_rd_data, w.d);
            last_a = w.a;
            last_d = w.d;
        end else begin
            chk("rf_w_en idle", {31'b0, rf_w_en}, 32'd0);
            chk("rf_rd_addr hold", {28'b0, rf_rd_addr}, {28'b0, last_a});
            chk("rf_rd_data hold", rf_rd_data, last_d);
        end
    endtask

    task automatic apply(input vec_t v, input int idx);
        wr_t w;
        alu_valid = v.av; alu_rd = v.ard; alu_data = v.adat;
        ld_valid  = v.lv; ld_rd  = v.lrd; ld_data  = v.ldat;
        iss_valid = v.iv; iss_rd = v.ird; chk_rn   = v.rn; chk_rm = v.rm;
        @(negedge clk);
        check_wr();
        chk($sformatf("alu_ready[%0d]", idx), {31'b0, alu_ready}, {31'b0, v.e_ar});
        chk($sformatf("ld_ready[%0d]", idx), {31'b0, ld_ready}, {31'b0, v.e_lr});
        chk($sformatf("iss_ok[%0d]", idx), {31'b0, iss_ok}, {31'b0, v.e_ok});
        chk($sformatf("rn_busy[%0d]", idx), {31'b0, rn_busy}, {31'b0, v.e_rnb});
        chk($sformatf("rm_busy[%0d]", idx), {31'b0, rm_busy}, {31'b0, v.e_rmb});
        if (v.e_lr) begin
            w.a = v.lrd; w.d = v.ldat; exp_q.push_back(w);
        end else if (v.e_ar) begin
            w.a = v.ard; w.d = v.adat; exp_q.push_back(w);
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        last_a = '0;
        last_d = '0;

        // Reset held with both requesters asserting.
        rst_n = 1'b0;
        alu_valid = 1'b1; alu_rd = 4'd3; alu_data = 32'hAAAA_0001;
        ld_valid  = 1'b1; ld_rd  = 4'd7; ld_data  = 32'hBBBB_0002;
        iss_valid = 1'b0; iss_rd = '0; chk_rn = '0; chk_rm = '0;
        #2;
        chk("rst rf_w_en", {31'b0, rf_w_en}, 32'd0);
        chk("rst alu_ready", {31'b0, alu_ready}, 32'd0);
        chk("rst ld_ready", {31'b0, ld_ready}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            iss_rd = i[3:0];
            #1;
            chk($sformatf("rst iss_ok[%0d]", i), {31'b0, iss_ok}, 32'd1);
        end
        repeat (2) @(posedge clk);
        @(negedge clk);
        alu_valid = 1'b0; ld_valid = 1'b0;
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 0, 15, 0, 0, 1, 0, 0));
        tbl.push_back(mk(1, 5, 32'hDEADBEEF, 0, 0, 0,            0, 0, 5, 5,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 0, 5, 5,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            1, 9, 9, 0,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            1, 9, 9, 9,  0, 0, 0, 1, 1));
        tbl.push_back(mk(0, 0, 0,            1, 9, 32'h12345678, 0, 9, 9, 0,  0, 1, 0, 1, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 9, 9, 9,  0, 0, 0, 1, 1));
        tbl.push_back(mk(1, 1, 32'h11,       0, 0, 0,            0, 9, 9, 1,  1, 0, 1, 0, 0));
`ifdef WB_RR_EN
        tbl.push_back(mk(1, 3, 32'hA3A3A3A3, 1, 7, 32'h77777777, 0, 0, 3, 7,  0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 3, 32'hA3A3A3A3, 1, 7, 32'h77777777, 0, 0, 3, 7,  1, 0, 1, 0, 0));
        tbl.push_back(mk(1, 3, 32'hA3A3A3A3, 1, 7, 32'h77777777, 0, 0, 3, 7,  0, 1, 1, 0, 0));
        tbl.push_back(mk(1, 3, 32'hA3A3A3A3, 1, 7, 32'h77777777, 0, 0, 3, 7,  1, 0, 1, 0, 0));
`else
        for (int i = 0; i < 4; i++) begin
            tbl.push_back(mk(1, 3, 32'hA3A3A3A3, 1, 7, 32'h77777777, 0, 0, 3, 7, 0, 1, 1, 0, 0));
        end
`endif
        tbl.push_back(mk(1, 4, 32'h44,       0, 0, 0,            0, 4, 4, 4,  1, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            1, 4, 4, 4,  0, 0, 1, 0, 0));
        tbl.push_back(mk(0, 0, 0,            0, 0, 0,            0, 4, 4, 9,  0, 0, 0, 1, 0));

        foreach (tbl[i]) apply(tbl[i], i);

        // Reset between accept and write: the accepted transfer and all reservations vanish.
        alu_valid = 1'b1; alu_rd = 4'd6; alu_data = 32'h66;
        ld_valid = 1'b0; iss_valid = 1'b1; iss_rd = 4'd2;
        @(posedge clk);
        #1;
        alu_valid = 1'b0; iss_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        chk("midrst rf_w_en", {31'b0, rf_w_en}, 32'd0);
        chk("midrst rf_rd_addr", {28'b0, rf_rd_addr}, 32'd0);
        for (int i = 0; i < 16; i++) begin
            chk_rn = i[3:0];
            #0.2;
            chk($sformatf("midrst busy[%0d]", i), {31'b0, rn_busy}, 32'd0);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        exp_q.delete();
        last_a = '0;
        last_d = '0;
        apply(mk(0, 0, 0, 0, 0, 0, 0, 2, 2, 4, 0, 0, 1, 0, 0), 100);
        apply(mk(0, 0, 0, 0, 0, 0, 0, 6, 6, 9, 0, 0, 1, 0, 0), 101);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/reg_wb_arbiter.md
Name: reg_wb_arbiter

Overview:
- Shares the single register-file write port (rd_addr / rd_data / w_en) between two writeback requesters: ALU and load unit.
- Holds a per-register busy scoreboard. Issue logic reserves a destination, and the scoreboard flags RAW/WAW hazards until that register's write lands.
- Sits between the execute/memory stages and the 16x32 register file. Its registered outputs drive the register-file write port directly.

Parameters:
- DATA_W, 32, writeback data width
- ADDR_W, 4, register address width; register count NREG = 2**ADDR_W (16)

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- alu_valid  in  1  ALU writeback request
- alu_ready  out  1  ALU request accepted this cycle
- alu_rd  in  ADDR_W  ALU destination register
- alu_data  in  DATA_W  ALU result
- ld_valid  in  1  load writeback request
- ld_ready  out  1  load request accepted this cycle
- ld_rd  in  ADDR_W  load destination register
- ld_data  in  DATA_W  load data
- rf_w_en  out  1  register-file write enable
- rf_rd_addr  out  ADDR_W  register-file write address
- rf_rd_data  out  DATA_W  register-file write data
- iss_valid  in  1  issue stage requests reservation of iss_rd
- iss_rd  in  ADDR_W  destination to reserve
- iss_ok  out  1  reservation granted (comb.)
- chk_rn  in  ADDR_W  source operand A to check
- chk_rm  in  ADDR_W  source operand B to check
- rn_busy  out  1  busy[chk_rn] (comb.)
- rm_busy  out  1  busy[chk_rm] (comb.)

Behaviour:
- Reset, async on rst_n low:
  - rf_w_en=0, rf_rd_addr=0, rf_rd_data=0
  - busy[15:0]=0
  - last-grant pointer = ALU, so load wins the first conflict
  - Reset mid-operation discards any accepted-but-unwritten transfer and all reservations.
- Handshake:
  - A transfer happens when valid && ready at a rising edge.
  - ready is combinational and is asserted only for the granted requester.
  - A requester must hold valid, rd and data stable until ready is seen.
- Grant:
  - Only one requester valid: it is granted.
  - Both valid: selection per the arbitration policy (see Optional Feature). The loser waits; there is no dropping.
- Latency:
  - A transfer accepted at edge N drives rf_w_en=1 with its rd/data during cycle N..N+1, for exactly one cycle.
  - The register file samples it at edge N+1.
  - With no transfer, rf_w_en=0 the next cycle; rf_rd_addr/rf_rd_data hold their last values.
- Throughput: one write per cycle; back-to-back transfers from either source are allowed with no bubble.
- Scoreboard:
  - Set: busy[iss_rd] is set at an edge where iss_valid && iss_ok.
  - iss_ok = ~busy[iss_rd]. A WAW stall is the issue stage's responsibility.
  - Clear: busy[rf_rd_addr] is cleared at an edge where rf_w_en=1.
  - Simultaneous set and clear of the same register: set wins.
  - A write to a non-busy register is legal; its clear is a no-op.
  - rn_busy and rm_busy are pure combinational lookups; chk_rn == chk_rm is legal.
- Register 0 has no special treatment; all 16 registers are general.

Optional Feature:
- Macro: WB_RR_EN
- Defined: round-robin arbitration. On a conflict, the requester not granted last wins. The pointer updates only on a granted transfer.
- Undefined: fixed priority, load over ALU. The pointer logic is absent and alu_ready = alu_valid & ~ld_valid.

Decomposition:
- Shared package reg_wb_pkg holds:
  - DATA_W and ADDR_W defaults
  - requester index constants REQ_ALU=0 and REQ_LD=1
  - the write-port bundle typedef (w_en, addr, data)
- One sub-module, wb_scoreboard: the 16-bit busy vector with set/clear and the two lookup ports. The arbiter and output register stay in the top module.

Test Plan:
- Reset: hold rst_n=0 with both valids high -> rf_w_en=0, both readys=0, iss_ok=1 for all iss_rd.
- ALU alone: alu_valid=1, alu_rd=5, alu_data=32'hDEADBEEF -> alu_ready=1, next cycle rf_w_en=1, rf_rd_addr=5, rf_rd_data=32'hDEADBEEF, then rf_w_en=0.
- Conflict over 4 cycles, both valid, rd 3 (ALU) / 7 (load):
  - WB_RR_EN defined: writes alternate 7, 3, 7, 3.
  - WB_RR_EN undefined: writes 7 every cycle and alu_ready stays 0.
- Scoreboard: reserve rd=9 -> iss_ok=1, then rn_busy=1 with chk_rn=9. A second reserve of 9 gives iss_ok=0. After a load write to 9, rn_busy=0 the cycle after rf_w_en.
- Simultaneous events: reserve rd=4 in the same cycle rf_w_en writes 4 -> busy[4]=1 afterwards.
- Mid-operation reset: pulse rst_n low between accept and write -> no rf_w_en, busy vector all zero.
